// File: rtl/shift_sequencer.sv
// Multi-cycle controller for the ALU barrel shifters.
// It splits a shift amount into chunks of at most MAX_CHUNK bits and issues
// one chunk per clock to the external 3-bit shifter. Each returned value is
// folded back into an accumulator. The handshake is START/BUSY/DONE.
module shift_sequencer #(
    parameter int MAX_CHUNK = 7,
    parameter int SAT_AMT   = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [1:0] OPCODE,
    input  logic [7:0] DATA,
    input  logic [7:0] AMOUNT,
    output logic [7:0] SH_DATA,
    output logic [2:0] SH_AMT,
    output logic       SH_SEL,
    output logic       SH_SETPIN,
    input  logic [7:0] SH_RESULT,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] RESULT,
    output logic       ERROR
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t     state;
    logic [7:0] acc;
    logic [3:0] rem;
    logic [1:0] op;
    logic       err_flag;

    logic [3:0] start_rem;
    logic [2:0] chunk_amt;
    logic [3:0] rem_after;

    // Reduce the requested amount to the number of bit positions that actually matter.
    // Shifts clamp at SAT_AMT. A rotate wraps modulo 8. The illegal opcode does no work.
    function automatic logic [3:0] reduce_amount(input logic [1:0] opc, input logic [7:0] amt);
        logic [3:0] r;
        case (opc)
            OP_SLL, OP_SRA: r = (amt >= 8'(SAT_AMT)) ? 4'(SAT_AMT) : amt[3:0];
            OP_ROR:         r = {1'b0, amt[2:0]};
            default:        r = 4'd0;
        endcase
        return r;
    endfunction

    // Largest chunk the shifter can take this cycle.
    function automatic logic [2:0] next_chunk(input logic [3:0] r);
        return (r > 4'(MAX_CHUNK)) ? 3'(MAX_CHUNK) : r[2:0];
    endfunction

    assign start_rem = reduce_amount(OPCODE, AMOUNT);
    assign chunk_amt = next_chunk(rem);
    assign rem_after = rem - {1'b0, chunk_amt};

    // The shifter interface follows the registered state. The shifter is only
    // steered while a chunk is being issued.
    assign SH_DATA   = acc;
    assign SH_AMT    = (state == S_RUN) ? chunk_amt : 3'd0;
    assign SH_SEL    = (state == S_RUN) && (op != OP_SLL);
    assign SH_SETPIN = (state == S_RUN) && (op == OP_SRA);

    // Sequencer FSM: accept, issue chunks, then report for one cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= S_IDLE;
            acc      <= 8'd0;
            rem      <= 4'd0;
            op       <= 2'b00;
            err_flag <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            RESULT   <= 8'd0;
            ERROR    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    DONE  <= 1'b0;
                    ERROR <= 1'b0;
                    if (START) begin
                        acc      <= DATA;
                        op       <= OPCODE;
                        err_flag <= (OPCODE == 2'b11);
                        rem      <= start_rem;
                        BUSY     <= 1'b1;
                        if (start_rem == 4'd0) begin
                            // Nothing to shift: the operand is the answer.
                            state  <= S_DONE;
                            DONE   <= 1'b1;
                            RESULT <= DATA;
                            ERROR  <= (OPCODE == 2'b11);
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    acc <= SH_RESULT;
                    rem <= rem_after;
                    if (rem_after == 4'd0) begin
                        state  <= S_DONE;
                        DONE   <= 1'b1;
                        RESULT <= SH_RESULT;
                        ERROR  <= err_flag;
                    end
                end
                S_DONE: begin
                    // A START seen here is ignored; the next request needs IDLE.
                    state <= S_IDLE;
                    DONE  <= 1'b0;
                    ERROR <= 1'b0;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    DONE  <= 1'b0;
                    ERROR <= 1'b0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule
